mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 141 ++++++++++++++
 tb/tb_mem_stage.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the EX bus, aligns and extends load data, and drives WB plus ID forwarding.
// Latency: one register stage; load data arrives live from SRAM or from a hold register while stalled.
// Backpressure: stall[3] holds the stage, stall[3] with stall[4] clear inserts a bubble, and flush zeroes it.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int STALL_W      = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic [STALL_W-1:0]      stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]             mem_to_id
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } rd_state_t;

    rd_state_t               state_q;
    rd_state_t               state_d;
    logic [EX_TO_MEM_WD-1:0] bus_q;
    logic [31:0]             hold_rdata;
    logic                    capture;

    logic stall_mem;
    logic stall_wb;
    logic bubble;
    logic advance;
    logic in_is_load;
    logic unused_stall;

    assign stall_mem    = stall[3];
    assign stall_wb     = stall[4];
    assign bubble       = stall_mem & ~stall_wb;
    assign advance      = ~stall_mem;
    assign unused_stall = ^stall;

    assign in_is_load = ex_to_mem_bus[43] & (ex_to_mem_bus[42:39] == 4'b0000) & ex_to_mem_bus[38];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_q <= '0;
        end else if (flush || bubble) begin
            bus_q <= '0;
        end else if (advance) begin
            bus_q <= ex_to_mem_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_rdata <= '0;
        end else if (capture) begin
            hold_rdata <= data_sram_rdata;
        end
    end

    // A load that sits in the register must stop sampling the SRAM port,
    // since the next request may already be driving new read data.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (flush || bubble) begin
            state_d = IDLE;
        end else if (advance) begin
            state_d = in_is_load ? FRESH : IDLE;
        end else begin
            case (state_q)
                FRESH: begin
                    state_d = HELD;
                    capture = 1'b1;
                end
                HELD:    state_d = HELD;
                default: state_d = IDLE;
            endcase
        end
    end

    logic [2:0]  mem_op;
    logic [31:0] pc;
    logic        is_load;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [31:0] rdata_eff;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    assign mem_op    = bus_q[78:76];
    assign pc        = bus_q[75:44];
    assign is_load   = bus_q[43] & (bus_q[42:39] == 4'b0000) & bus_q[38];
    assign rf_we     = bus_q[37];
    assign rf_waddr  = bus_q[36:32];
    assign ex_result = bus_q[31:0];

    assign rdata_eff = (state_q == HELD) ? hold_rdata : data_sram_rdata;

    always_comb begin
        byte_sel = rdata_eff[7:0];
        case (ex_result[1:0])
            2'd1:    byte_sel = rdata_eff[15:8];
            2'd2:    byte_sel = rdata_eff[23:16];
            2'd3:    byte_sel = rdata_eff[31:24];
            default: byte_sel = rdata_eff[7:0];
        endcase
    end

    assign half_sel = ex_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];

    always_comb begin
        load_data = rdata_eff;
        case (mem_op)
            3'b001:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_data = {24'd0, byte_sel};
            3'b011:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {16'd0, half_sel};
            default: load_data = rdata_eff;
        endcase
    end

    assign rf_wdata      = is_load ? load_data : ex_result;
    assign mem_to_wb_bus = {pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_id     = mem_to_wb_bus[37:0];

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extension, stall hold, bubble, flush and asynchronous reset.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        flush = 1'b0;
    logic [5:0]  stall = 6'd0;
    logic [78:0] ex_to_mem_bus = '0;
    logic [31:0] data_sram_rdata = '0;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id;

    int total = 0;
    int bad = 0;

    localparam logic [5:0] ST_NONE   = 6'b000000;
    localparam logic [5:0] ST_HOLD   = 6'b011000;
    localparam logic [5:0] ST_BUBBLE = 6'b001000;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id       (mem_to_id)
    );

    always #5 clk = ~clk;

    function automatic logic [78:0] mk_load(input logic [2:0] op, input logic [31:0] pc,
                                            input logic [4:0] waddr, input logic [31:0] addr);
        return {op, pc, 1'b1, 4'b0000, 1'b1, 1'b1, waddr, addr};
    endfunction

    function automatic logic [78:0] mk_alu(input logic [31:0] pc, input logic we,
                                           input logic [4:0] waddr, input logic [31:0] res);
        return {3'b000, pc, 1'b0, 4'b0000, 1'b0, we, waddr, res};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #1 resetn = 1'b0;
        step();
        chk("reset_wb", mem_to_wb_bus, 70'd0);
        chk("reset_id", {32'd0, mem_to_id}, 70'd0);
        #2 resetn = 1'b1;

        // LW, one cycle after capture, live SRAM data
        ex_to_mem_bus = mk_load(3'b000, 32'h0000_1000, 5'd3, 32'h0000_0100);
        step();
        data_sram_rdata = 32'h8899_AABB;
        #1;
        chk("lw_basic", mem_to_wb_bus, {32'h0000_1000, 1'b1, 5'd3, 32'h8899_AABB});

        // Sub-word extensions against rdata 0x80FF7F01
        ex_to_mem_bus = mk_load(3'b001, 32'h0000_1004, 5'd4, 32'h0000_0103);
        step();
        data_sram_rdata = 32'h80FF_7F01;
        #1;
        chk("lb", mem_to_wb_bus, {32'h0000_1004, 1'b1, 5'd4, 32'hFFFF_FF80});
        ex_to_mem_bus = mk_load(3'b010, 32'h0000_1008, 5'd4, 32'h0000_0103);
        step();
        chk("lbu", mem_to_wb_bus, {32'h0000_1008, 1'b1, 5'd4, 32'h0000_0080});
        ex_to_mem_bus = mk_load(3'b011, 32'h0000_100C, 5'd4, 32'h0000_0102);
        step();
        chk("lh", mem_to_wb_bus, {32'h0000_100C, 1'b1, 5'd4, 32'hFFFF_80FF});
        ex_to_mem_bus = mk_load(3'b100, 32'h0000_1010, 5'd4, 32'h0000_0103);
        step();
        chk("lhu_odd", mem_to_wb_bus, {32'h0000_1010, 1'b1, 5'd4, 32'h0000_80FF});
        ex_to_mem_bus = mk_load(3'b001, 32'h0000_1014, 5'd4, 32'h0000_0101);
        step();
        chk("lb_lane1", mem_to_wb_bus, {32'h0000_1014, 1'b1, 5'd4, 32'h0000_007F});
        ex_to_mem_bus = mk_load(3'b110, 32'h0000_1018, 5'd4, 32'h0000_0101);
        step();
        chk("op110_lw", mem_to_wb_bus, {32'h0000_1018, 1'b1, 5'd4, 32'h80FF_7F01});

        // ALU result bypasses the load mux
        ex_to_mem_bus = mk_alu(32'h0000_2000, 1'b1, 5'd5, 32'h0000_0007);
        step();
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        chk("add_fwd", {32'd0, mem_to_id}, {32'd0, 1'b1, 5'd5, 32'h0000_0007});

        // Store passes ex_result through with rf_we clear
        ex_to_mem_bus = {3'b000, 32'h0000_2004, 1'b1, 4'b1111, 1'b0, 1'b0, 5'd0, 32'h0000_0200};
        step();
        chk("store", mem_to_wb_bus, {32'h0000_2004, 1'b0, 5'd0, 32'h0000_0200});

        // LW then stall: captured word survives SRAM port changes
        ex_to_mem_bus = mk_load(3'b000, 32'h0000_3000, 5'd7, 32'h0000_0200);
        step();
        data_sram_rdata = 32'h1234_5678;
        #1;
        chk("lw_fresh", mem_to_wb_bus, {32'h0000_3000, 1'b1, 5'd7, 32'h1234_5678});
        stall = ST_HOLD;
        ex_to_mem_bus = mk_alu(32'h0000_3004, 1'b1, 5'd9, 32'h0000_0009);
        step();
        data_sram_rdata = 32'hDEAD_BEEF;
        #1;
        chk("held_1", mem_to_wb_bus, {32'h0000_3000, 1'b1, 5'd7, 32'h1234_5678});
        step();
        chk("held_2", mem_to_wb_bus, {32'h0000_3000, 1'b1, 5'd7, 32'h1234_5678});
        step();
        chk("held_3_id", {32'd0, mem_to_id}, {32'd0, 1'b1, 5'd7, 32'h1234_5678});

        // Flush while held wins over stall
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_held", mem_to_wb_bus, 70'd0);
        // Back in IDLE: a new load sees live data
        stall = ST_NONE;
        ex_to_mem_bus = mk_load(3'b000, 32'h0000_3008, 5'd8, 32'h0000_0300);
        step();
        data_sram_rdata = 32'h0BAD_F00D;
        #1;
        chk("post_flush_ld", mem_to_wb_bus, {32'h0000_3008, 1'b1, 5'd8, 32'h0BAD_F00D});

        // Bubble: stall[3] set with stall[4] clear
        ex_to_mem_bus = mk_alu(32'h0000_4000, 1'b1, 5'd10, 32'h0000_00AA);
        step();
        chk("pre_bubble", mem_to_wb_bus, {32'h0000_4000, 1'b1, 5'd10, 32'h0000_00AA});
        stall = ST_BUBBLE;
        step();
        chk("bubble", mem_to_wb_bus, 70'd0);

        // Asynchronous reset in the middle of HELD
        stall = ST_NONE;
        ex_to_mem_bus = mk_load(3'b000, 32'h0000_5000, 5'd11, 32'h0000_0400);
        step();
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        stall = ST_HOLD;
        step();
        data_sram_rdata = 32'h0000_0000;
        #1;
        chk("held_pre_rst", mem_to_wb_bus, {32'h0000_5000, 1'b1, 5'd11, 32'hCAFE_F00D});
        #2 resetn = 1'b0;
        #1;
        chk("async_rst", mem_to_wb_bus, 70'd0);
        step();
        resetn = 1'b1;
        step();
        chk("rst_rel_stall", mem_to_wb_bus, 70'd0);
        stall = ST_NONE;
        step();
        data_sram_rdata = 32'h1357_2468;
        #1;
        chk("post_rst_ld", mem_to_wb_bus, {32'h0000_5000, 1'b1, 5'd11, 32'h1357_2468});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
